// File: rtl/draw_pkg.sv
// Shared types for the rectangle draw command path: field widths, command payload, sequencer states.
package draw_pkg;

  localparam int unsigned X_W = 8;
  localparam int unsigned Y_W = 7;
  localparam int unsigned S_W = 5;
  localparam int unsigned C_W = 3;

  typedef struct packed {
    logic [X_W-1:0] x;
    logic [Y_W-1:0] y;
    logic [S_W-1:0] w;
    logic [S_W-1:0] h;
    logic [C_W-1:0] c;
  } rect_cmd_t;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    RUN,
    RELEASE
  } seq_state_t;

endpackage

// File: rtl/rect_fifo.sv
// Synchronous FIFO of rectangle commands; power-of-two depth, wrapping pointers, separate occupancy counter.
module rect_fifo
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                           clk,
  input  logic                           resetn,
  input  logic                           push,
  input  rect_cmd_t                      push_data,
  input  logic                           pop,
  output rect_cmd_t                      head,
  output logic                           full,
  output logic                           empty,
  output logic [$clog2(DEPTH+1)-1:0]     count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);

  rect_cmd_t         mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              do_push;
  logic              do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign head    = mem[rd_ptr];

  // Storage needs no reset; pointers and count define what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/draw_sequencer.sv
// Queues rectangle commands and walks the draw engine through update/draw/done for each one in order.
module draw_sequencer
  import draw_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                        clk,
  input  logic                        resetn,
  input  logic                        cmd_valid,
  output logic                        cmd_ready,
  input  logic [X_W-1:0]              cmd_x,
  input  logic [Y_W-1:0]              cmd_y,
  input  logic [S_W-1:0]              cmd_w,
  input  logic [S_W-1:0]              cmd_h,
  input  logic [C_W-1:0]              cmd_c,
  output logic                        draw,
  output logic                        update,
  output logic [X_W-1:0]              rect_x,
  output logic [Y_W-1:0]              rect_y,
  output logic [S_W-1:0]              rect_w,
  output logic [S_W-1:0]              rect_h,
  output logic [C_W-1:0]              rect_c,
  input  logic                        draw_done,
  output logic                        busy,
  output logic [$clog2(DEPTH+1)-1:0]  count
);

  seq_state_t state_q;
  seq_state_t state_d;
  rect_cmd_t  cmd_in;
  rect_cmd_t  fifo_head;
  rect_cmd_t  rect_q;
  logic       fifo_full;
  logic       fifo_empty;
  logic       push;
  logic       pop;
  logic       draw_d;
  logic       update_d;
  logic       busy_d;

  assign cmd_in    = '{x: cmd_x, y: cmd_y, w: cmd_w, h: cmd_h, c: cmd_c};
  assign cmd_ready = !fifo_full;
  // Zero-size rectangles are acknowledged but dropped so the engine never sees width/height 0.
  assign push      = cmd_valid && !fifo_full && (cmd_w != '0) && (cmd_h != '0);

  rect_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .resetn    (resetn),
    .push      (push),
    .push_data (cmd_in),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (count)
  );

  always_comb begin
    state_d  = state_q;
    pop      = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      LOAD:    state_d = RUN;
      RUN:     if (draw_done) state_d = RELEASE;
      RELEASE: begin
        state_d = IDLE;
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = LOAD;
        end
      end
      default: state_d = IDLE;
    endcase
    // Outputs are decoded from the next state so they register in step with it.
    draw_d   = (state_d == LOAD) || (state_d == RUN);
    update_d = (state_d == LOAD);
    busy_d   = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      draw    <= 1'b0;
      update  <= 1'b0;
      busy    <= 1'b0;
      rect_q  <= '0;
    end else begin
      state_q <= state_d;
      draw    <= draw_d;
      update  <= update_d;
      busy    <= busy_d;
      if (pop) rect_q <= fifo_head;
    end
  end

  assign rect_x = rect_q.x;
  assign rect_y = rect_q.y;
  assign rect_w = rect_q.w;
  assign rect_h = rect_q.h;
  assign rect_c = rect_q.c;

endmodule

// File: tb/tb_draw_sequencer.sv
// Randomized and directed bench for draw_sequencer against a queue-based command model and an engine model.
module tb_draw_sequencer;
  import draw_pkg::*;

  localparam int unsigned DEPTH = 8;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [7:0] cmd_x;
  logic [6:0] cmd_y;
  logic [4:0] cmd_w;
  logic [4:0] cmd_h;
  logic [2:0] cmd_c;
  logic       draw;
  logic       update;
  logic [7:0] rect_x;
  logic [6:0] rect_y;
  logic [4:0] rect_w;
  logic [4:0] rect_h;
  logic [2:0] rect_c;
  logic       draw_done;
  logic       busy;
  logic [3:0] count;

  logic        stall = 1'b0;
  logic        spurious = 1'b0;
  logic        vga_en = 1'b0;
  logic        eng_done;
  logic [10:0] eng_left;
  int          eng_pix;

  int n_checks = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  draw_sequencer #(.DEPTH(DEPTH)) dut (
    .clk       (clk),
    .resetn    (resetn),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_x     (cmd_x),
    .cmd_y     (cmd_y),
    .cmd_w     (cmd_w),
    .cmd_h     (cmd_h),
    .cmd_c     (cmd_c),
    .draw      (draw),
    .update    (update),
    .rect_x    (rect_x),
    .rect_y    (rect_y),
    .rect_w    (rect_w),
    .rect_h    (rect_h),
    .rect_c    (rect_c),
    .draw_done (draw_done),
    .busy      (busy),
    .count     (count)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Engine: latches size on update, counts w*h pixel strobes, then holds done until draw drops.
  assign draw_done = (eng_done && !stall) || spurious;

  always @(negedge clk) vga_en = 1'($urandom_range(0, 1));

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      eng_left <= '0;
      eng_done <= 1'b0;
      eng_pix  <= 0;
    end else if (draw && update) begin
      eng_left <= 11'(rect_w) * 11'(rect_h);
      eng_done <= 1'b0;
      eng_pix  <= 0;
    end else if (!draw) begin
      eng_done <= 1'b0;
    end else if (!eng_done && vga_en) begin
      eng_pix  <= eng_pix + 1;
      eng_left <= eng_left - 11'd1;
      if (eng_left <= 11'd1) eng_done <= 1'b1;
    end
  end

  // Reference model: queue of accepted non-empty commands plus the handshake rules seen on the pins.
  rect_cmd_t exp_q[$];
  rect_cmd_t cur = '0;
  rect_cmd_t p_cmd;
  logic      p_draw, p_update, p_done, p_acc;
  int        q0;

  always @(posedge clk) begin
    p_draw   = draw;
    p_update = update;
    p_done   = draw_done;
    p_acc    = resetn && cmd_valid && cmd_ready;
    p_cmd    = '{cmd_x, cmd_y, cmd_w, cmd_h, cmd_c};
    #1;
    if (!resetn) begin
      exp_q.delete();
      cur = '0;
    end else begin
      q0 = exp_q.size();
      if (p_update) begin
        check("load_then_draw", 32'(draw), 32'd1);
        check("load_one_cycle", 32'(update), 32'd0);
      end else if (p_draw && p_done) begin
        check("release_draw", 32'(draw), 32'd0);
        check("release_upd", 32'(update), 32'd0);
        check("release_busy", 32'(busy), 32'd1);
      end else if (p_draw) begin
        check("run_hold_draw", 32'(draw), 32'd1);
        check("run_hold_upd", 32'(update), 32'd0);
      end else begin
        check("pop_update", 32'(update), 32'(q0 > 0));
        check("pop_draw", 32'(draw), 32'(q0 > 0));
        check("pop_busy", 32'(busy), 32'(q0 > 0));
      end
      if (p_acc && p_cmd.w != 0 && p_cmd.h != 0) exp_q.push_back(p_cmd);
      if (update) begin
        if (exp_q.size() == 0) check("pop_from_empty", 32'd0, 32'd1);
        else cur = exp_q.pop_front();
      end
      check("rect", 32'({rect_x, rect_y, rect_w, rect_h, rect_c}), 32'(cur));
      check("count", 32'(count), 32'(exp_q.size()));
      check("cmd_ready", 32'(cmd_ready), 32'(exp_q.size() != DEPTH));
    end
  end

  task automatic send(input logic [7:0] x, input logic [6:0] y, input logic [4:0] w,
                      input logic [4:0] h, input logic [2:0] c);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_c = c;
    for (int i = 0; i < 1000 && !ok; i++) begin
      @(posedge clk);
      ok = cmd_ready;
      #1;
    end
    cmd_valid = 1'b0;
    if (!ok) check("send_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int i = 0; i < 3000 && !ok; i++) begin
      @(posedge clk);
      #1;
      ok = !busy && count == 0;
    end
    check("idle_reached", 32'(ok), 32'd1);
  endtask

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    logic [4:0] rw, rh;
    cmd_valid = 1'b0;
    cmd_x = '0; cmd_y = '0; cmd_w = '0; cmd_h = '0; cmd_c = '0;
    tick(2);
    check("rst_draw", 32'(draw), 32'd0);
    check("rst_update", 32'(update), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_rect", 32'({rect_x, rect_y, rect_w, rect_h, rect_c}), 32'd0);
    check("rst_ready", 32'(cmd_ready), 32'd1);
    #2 resetn = 1'b1;
    tick(2);

    // Single command timing and pixel count
    send(8'd10, 7'd20, 5'd3, 5'd2, 3'd5);
    check("single_count", 32'(count), 32'd1);
    tick(1);
    check("single_load_upd", 32'(update), 32'd1);
    check("single_load_draw", 32'(draw), 32'd1);
    check("single_load_x", 32'(rect_x), 32'd10);
    tick(1);
    check("single_run_upd", 32'(update), 32'd0);
    check("single_run_draw", 32'(draw), 32'd1);
    wait_idle();
    check("single_pixels", 32'(eng_pix), 32'd6);

    // Fill while stalled: one in flight plus DEPTH queued
    stall = 1'b1;
    for (int i = 0; i < 9; i++) send(8'(i * 7), 7'(i + 3), 5'(i % 3 + 1), 5'd2, 3'(i));
    tick(1);
    check("full_count", 32'(count), 32'd8);
    check("full_ready", 32'(cmd_ready), 32'd0);
    cmd_valid = 1'b1; cmd_x = 8'hAA; cmd_w = 5'd1; cmd_h = 5'd1;
    tick(3);
    cmd_valid = 1'b0;
    check("full_no_push", 32'(count), 32'd8);
    stall = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      tick(1);
      ok = cmd_ready;
    end
    check("full_ready_back", 32'(cmd_ready), 32'd1);
    check("full_count_after", 32'(count), 32'd7);
    wait_idle();

    // Zero-size commands interleaved
    send(8'd1, 7'd1, 5'd0, 5'd3, 3'd1);
    check("zero_count", 32'(count), 32'd0);
    tick(2);
    check("zero_idle", 32'(busy), 32'd0);
    send(8'd2, 7'd2, 5'd2, 5'd2, 3'd2);
    send(8'd3, 7'd3, 5'd4, 5'd0, 3'd3);
    send(8'd4, 7'd4, 5'd1, 5'd1, 3'd4);
    wait_idle();

    // Three back-to-back commands
    stall = 1'b1;
    send(8'd50, 7'd60, 5'd2, 5'd1, 3'd1);
    send(8'd51, 7'd61, 5'd1, 5'd3, 3'd2);
    send(8'd52, 7'd62, 5'd2, 5'd2, 3'd3);
    stall = 1'b0;
    wait_idle();

    // Reset mid-run with four queued
    stall = 1'b1;
    for (int i = 0; i < 5; i++) send(8'(100 + i), 7'(i), 5'd2, 5'd2, 3'(i));
    tick(3);
    check("prerst_count", 32'(count), 32'd4);
    check("prerst_draw", 32'(draw), 32'd1);
    @(posedge clk);
    #3 resetn = 1'b0;
    #1;
    check("midrst_draw", 32'(draw), 32'd0);
    check("midrst_count", 32'(count), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_rect", 32'(rect_x), 32'd0);
    repeat (2) @(posedge clk);
    #3 resetn = 1'b1;
    stall = 1'b0;
    tick(10);
    check("postrst_idle", 32'(busy), 32'd0);
    send(8'd77, 7'd33, 5'd1, 5'd2, 3'd6);
    wait_idle();

    // Spurious done in IDLE and LOAD
    spurious = 1'b1;
    tick(5);
    check("spur_idle", 32'(busy), 32'd0);
    send(8'd9, 7'd9, 5'd2, 5'd3, 3'd7);
    tick(1);
    check("spur_load_upd", 32'(update), 32'd1);
    tick(1);
    check("spur_run_draw", 32'(draw), 32'd1);
    check("spur_run_upd", 32'(update), 32'd0);
    spurious = 1'b0;
    wait_idle();

    // Random traffic
    for (int k = 0; k < 120; k++) begin
      rw = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 4));
      rh = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom_range(1, 4));
      send(8'($urandom), 7'($urandom), rw, rh, 3'($urandom));
      tick($urandom_range(0, 6));
    end
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
